// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game blocks (paddle and ball engines).
// Geometry is in 640x480 active-pixel coordinates, centre-referenced.
// Contents: screen/paddle dimensions, paddle X centres, ball state enum,
// and small signed-arithmetic helpers for the collision compares.
package pong_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int PADDLE_W  = 20;
  localparam int PADDLE_H  = 40;
  localparam int PADDLE1_X = 30;
  localparam int PADDLE2_X = 610;

  localparam logic [9:0]  X_CENTRE = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_CENTRE = 10'(V_ACTIVE / 2);
  localparam logic [11:0] BALL_RGB = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    POINT,
    OVER
  } ball_state_e;

  // Widen a 10-bit coordinate so edge tests near 0 can go negative
  // instead of wrapping.
  function automatic logic signed [11:0] toS(logic [9:0] v);
    return signed'({2'b00, v});
  endfunction

  function automatic logic [11:0] absDiff(logic signed [11:0] a,
                                          logic signed [11:0] b);
    logic signed [11:0] d;
    d = a - b;
    return (d < 12'sd0) ? unsigned'(-d) : unsigned'(d);
  endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Bundle between the ball engine and its surroundings (paddle block, VGA
// timing, VGA mixer, serve button).
// Ports:
//   serve                       serve/restart button, active-low
//   x, y                        current VGA pixel
//   x_paddle1..y_paddle2        paddle centres (left, right)
//   x_ball, y_ball              ball centre
//   ball_on, rgb_ball           ball pixel mask and colour
//   score1, score2, game_over   game status
// The master side drives the game inputs, the slave side is the ball engine.
interface ball_ctrl_if;

  logic       serve;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] x_paddle1;
  logic [9:0] y_paddle1;
  logic [9:0] x_paddle2;
  logic [9:0] y_paddle2;

  logic [9:0]  x_ball;
  logic [9:0]  y_ball;
  logic        ball_on;
  logic [11:0] rgb_ball;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        game_over;

  modport master (
    output serve, x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2,
    input  x_ball, y_ball, ball_on, rgb_ball, score1, score2, game_over
  );

  modport slave (
    input  serve, x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2,
    output x_ball, y_ball, ball_on, rgb_ball, score1, score2, game_over
  );

endinterface

// File: rtl/pong_tick_gen.sv
// Periodic tick generator on the 1 ms game clock.
// Ports:
//   clk_1ms  in  game clock
//   reset    in  sync, active-low
//   clear_i  in  holds the count at 0 and suppresses the tick
//   tick_o   out one-cycle pulse on every PERIOD-th uncleared cycle
// The first tick after clear_i drops arrives PERIOD cycles later.
module pong_tick_gen #(
  parameter int PERIOD = 10
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  // At least one counter bit so PERIOD==1 still elaborates.
  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/ball_ctrl.sv
// Ball engine: owns ball motion, wall bounces, paddle hits and misses, the
// two score counters and game-over. Provides the ball mask/colour for the
// VGA mixer.
// Ports:
//   clk_1ms  in  1 ms game clock
//   reset    in  sync, active-low
//   bus      ball_ctrl_if.slave (serve, pixel, paddle centres in;
//            ball position, mask, colour, scores, game_over out)
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int STEP_MS   = 10,
  parameter int BALL_HALF = 4,
  parameter int PAUSE_MS  = 1000,
  parameter int WIN_SCORE = 7
) (
  input  logic       clk_1ms,
  input  logic       reset,
  ball_ctrl_if.slave bus
);

  localparam logic signed [11:0] HALF_S   = 12'(BALL_HALF);
  localparam logic signed [11:0] PAD_DX_S = 12'(PADDLE_W / 2);
  localparam logic [11:0]        REACH_Y  = 12'(PADDLE_H / 2 + BALL_HALF);
  localparam logic signed [11:0] X_EDGE_S = 12'(H_ACTIVE - 1);
  localparam logic signed [11:0] Y_EDGE_S = 12'(V_ACTIVE - 1);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

  ball_state_e state_q, state_d;
  logic [9:0]  xBall_q, xBall_d;
  logic [9:0]  yBall_q, yBall_d;
  logic        dxPos_q, dxPos_d;
  logic        dyPos_q, dyPos_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic        missRight_q, missRight_d;

  logic stepTick;
  logic pauseTick;

  pong_tick_gen #(.PERIOD(STEP_MS)) stepGen (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .clear_i (state_q != PLAY),
    .tick_o  (stepTick)
  );

  pong_tick_gen #(.PERIOD(PAUSE_MS)) pauseGen (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .clear_i (state_q != POINT),
    .tick_o  (pauseTick)
  );

  logic [9:0]         nx, ny;
  logic signed [11:0] nxS, nyS;
  logic hitTop, hitBottom, hitLeft, hitRight, missLeft, missRightEdge;

  assign nx  = dxPos_q ? xBall_q + 10'd1 : xBall_q - 10'd1;
  assign ny  = dyPos_q ? yBall_q + 10'd1 : yBall_q - 10'd1;
  assign nxS = toS(nx);
  assign nyS = toS(ny);

  // All collision tests look at the candidate position, not the current one.
  assign hitTop    = (nyS - HALF_S) <= 12'sd0;
  assign hitBottom = (nyS + HALF_S) >= Y_EDGE_S;

  assign hitLeft  = !dxPos_q
                 && ((nxS - HALF_S) <= (toS(bus.x_paddle1) + PAD_DX_S))
                 && ((nxS - HALF_S) >= (toS(bus.x_paddle1) - PAD_DX_S))
                 && (absDiff(nyS, toS(bus.y_paddle1)) < REACH_Y);

  assign hitRight = dxPos_q
                 && ((nxS + HALF_S) >= (toS(bus.x_paddle2) - PAD_DX_S))
                 && ((nxS + HALF_S) <= (toS(bus.x_paddle2) + PAD_DX_S))
                 && (absDiff(nyS, toS(bus.y_paddle2)) < REACH_Y);

  assign missLeft      = (nxS - HALF_S) <= 12'sd0;
  assign missRightEdge = (nxS + HALF_S) >= X_EDGE_S;

  always_comb begin
    state_d     = state_q;
    xBall_d     = xBall_q;
    yBall_d     = yBall_q;
    dxPos_d     = dxPos_q;
    dyPos_d     = dyPos_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    missRight_d = missRight_q;

    case (state_q)
      IDLE: begin
        xBall_d = X_CENTRE;
        yBall_d = Y_CENTRE;
        if (!bus.serve) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (stepTick) begin
          xBall_d = nx;
          yBall_d = ny;
          if (hitTop) begin
            dyPos_d = 1'b1;
          end
          if (hitBottom) begin
            dyPos_d = 1'b0;
          end
          if (hitLeft) begin
            dxPos_d = 1'b1;
          end
          if (hitRight) begin
            dxPos_d = 1'b0;
          end
          // A paddle return overrides a miss on the same step.
          if (!hitLeft && !hitRight) begin
            if (missLeft) begin
              if (score2_q < WIN) begin
                score2_d = score2_q + 4'd1;
              end
              missRight_d = 1'b0;
              state_d     = POINT;
            end else if (missRightEdge) begin
              if (score1_q < WIN) begin
                score1_d = score1_q + 4'd1;
              end
              missRight_d = 1'b1;
              state_d     = POINT;
            end
          end
        end
      end

      POINT: begin
        if (pauseTick) begin
          xBall_d = X_CENTRE;
          yBall_d = Y_CENTRE;
          // Next serve heads toward the player who just missed.
          dxPos_d = missRight_q;
          state_d = (score1_q == WIN || score2_q == WIN) ? OVER : IDLE;
        end
      end

      OVER: begin
        xBall_d = X_CENTRE;
        yBall_d = Y_CENTRE;
        if (!bus.serve) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state_q     <= IDLE;
      xBall_q     <= X_CENTRE;
      yBall_q     <= Y_CENTRE;
      dxPos_q     <= 1'b1;
      dyPos_q     <= 1'b1;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      missRight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xBall_q     <= xBall_d;
      yBall_q     <= yBall_d;
      dxPos_q     <= dxPos_d;
      dyPos_q     <= dyPos_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      missRight_q <= missRight_d;
    end
  end

  logic signed [11:0] xbS, ybS, pxS, pyS;

  assign xbS = toS(xBall_q);
  assign ybS = toS(yBall_q);
  assign pxS = toS(bus.x);
  assign pyS = toS(bus.y);

  assign bus.ball_on = (pxS >= xbS - HALF_S) && (pxS < xbS + HALF_S)
                    && (pyS >= ybS - HALF_S) && (pyS < ybS + HALF_S);

  assign bus.x_ball    = xBall_q;
  assign bus.y_ball    = yBall_q;
  assign bus.rgb_ball  = BALL_RGB;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.game_over = (state_q == OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Testbench for ball_ctrl: directed game scenarios with fixed expectations,
// a ball_on pixel table, a full game to game-over, and a randomized run
// compared cycle by cycle against a rule-level game model.
module tb_ball_ctrl;
  import pong_pkg::*;

  localparam int STEP_MS   = 1;
  localparam int PAUSE_MS  = 5;
  localparam int BALL_HALF = 4;
  localparam int WIN_SCORE = 7;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_POINT = 2;
  localparam int M_OVER  = 3;

  logic clk_1ms = 1'b0;
  logic reset   = 1'b0;

  ball_ctrl_if bus ();

  ball_ctrl #(
    .STEP_MS   (STEP_MS),
    .BALL_HALF (BALL_HALF),
    .PAUSE_MS  (PAUSE_MS),
    .WIN_SCORE (WIN_SCORE)
  ) dut (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_1ms = ~clk_1ms;

  int compared   = 0;
  int mismatched = 0;

  // Game model, in plain integers: state code, position, direction (+1/-1),
  // scores, and edges spent in the current PLAY / POINT phase.
  int mState, mx, my, mdx, mdy, ms1, ms2, mPlayEdges, mPointEdges;
  bit mMissRight;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       expOn;
  } pixVec_t;

  pixVec_t pixVecs [12];

  function automatic int absI(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit modelBallOn(int px, int py);
    return (px >= mx - BALL_HALF) && (px < mx + BALL_HALF)
        && (py >= my - BALL_HALF) && (py < my + BALL_HALF);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic modelEdge();
    int nx, ny, xp1, yp1, xp2, yp2;
    bit hitL, hitR;
    if (reset == 1'b0) begin
      mState = M_IDLE; mx = 320; my = 240; mdx = 1; mdy = 1;
      ms1 = 0; ms2 = 0; mPlayEdges = 0; mPointEdges = 0; mMissRight = 1'b0;
      return;
    end
    xp1 = bus.x_paddle1; yp1 = bus.y_paddle1;
    xp2 = bus.x_paddle2; yp2 = bus.y_paddle2;
    case (mState)
      M_IDLE: begin
        if (!bus.serve) begin
          mState = M_PLAY;
          mPlayEdges = 0;
        end
      end
      M_PLAY: begin
        mPlayEdges++;
        if (mPlayEdges % STEP_MS == 0) begin
          nx = mx + mdx;
          ny = my + mdy;
          hitL = (mdx < 0) && (nx - BALL_HALF <= xp1 + 10) && (nx - BALL_HALF >= xp1 - 10)
              && (absI(ny - yp1) < 20 + BALL_HALF);
          hitR = (mdx > 0) && (nx + BALL_HALF >= xp2 - 10) && (nx + BALL_HALF <= xp2 + 10)
              && (absI(ny - yp2) < 20 + BALL_HALF);
          if (ny - BALL_HALF <= 0) mdy = 1;
          if (ny + BALL_HALF >= 479) mdy = -1;
          if (hitL) mdx = 1;
          if (hitR) mdx = -1;
          mx = nx;
          my = ny;
          if (!hitL && !hitR) begin
            if (nx - BALL_HALF <= 0) begin
              if (ms2 < WIN_SCORE) ms2++;
              mMissRight = 1'b0;
              mState = M_POINT;
              mPointEdges = 0;
            end else if (nx + BALL_HALF >= 639) begin
              if (ms1 < WIN_SCORE) ms1++;
              mMissRight = 1'b1;
              mState = M_POINT;
              mPointEdges = 0;
            end
          end
        end
      end
      M_POINT: begin
        mPointEdges++;
        if (mPointEdges == PAUSE_MS) begin
          mx = 320;
          my = 240;
          mdx = mMissRight ? 1 : -1;
          mState = (ms1 == WIN_SCORE || ms2 == WIN_SCORE) ? M_OVER : M_IDLE;
        end
      end
      default: begin
        if (!bus.serve) begin
          ms1 = 0;
          ms2 = 0;
          mState = M_IDLE;
        end
      end
    endcase
  endtask

  // One clock: model follows the edge, then return at the falling edge where
  // outputs are sampled and new inputs are driven.
  task automatic clockCycle();
    @(posedge clk_1ms);
    modelEdge();
    @(negedge clk_1ms);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) clockCycle();
  endtask

  task automatic applyStimulus(input logic serveIn, input int yp1, input int yp2);
    bus.serve     = serveIn;
    bus.x_paddle1 = 10'(PADDLE1_X);
    bus.x_paddle2 = 10'(PADDLE2_X);
    bus.y_paddle1 = 10'(yp1);
    bus.y_paddle2 = 10'(yp2);
  endtask

  task automatic doReset();
    reset = 1'b0;
    runCycles(2);
    reset = 1'b1;
  endtask

  task automatic checkBall(input string tag, input int ex, input int ey);
    checkOutput({tag, " x_ball"}, bus.x_ball, ex);
    checkOutput({tag, " y_ball"}, bus.y_ball, ey);
  endtask

  task automatic compareAll();
    checkOutput("model x_ball", bus.x_ball, mx);
    checkOutput("model y_ball", bus.y_ball, my);
    checkOutput("model score1", bus.score1, ms1);
    checkOutput("model score2", bus.score2, ms2);
    checkOutput("model game_over", bus.game_over, (mState == M_OVER) ? 1 : 0);
    checkOutput("model ball_on", bus.ball_on, modelBallOn(bus.x, bus.y));
  endtask

  initial begin
    pixVecs[0]  = '{10'd316, 10'd236, 1'b1};
    pixVecs[1]  = '{10'd323, 10'd243, 1'b1};
    pixVecs[2]  = '{10'd315, 10'd240, 1'b0};
    pixVecs[3]  = '{10'd324, 10'd240, 1'b0};
    pixVecs[4]  = '{10'd320, 10'd235, 1'b0};
    pixVecs[5]  = '{10'd320, 10'd244, 1'b0};
    pixVecs[6]  = '{10'd320, 10'd240, 1'b1};
    pixVecs[7]  = '{10'd316, 10'd243, 1'b1};
    pixVecs[8]  = '{10'd323, 10'd236, 1'b1};
    pixVecs[9]  = '{10'd315, 10'd235, 1'b0};
    pixVecs[10] = '{10'd0,   10'd0,   1'b0};
    pixVecs[11] = '{10'd639, 10'd479, 1'b0};

    bus.x = 10'd0;
    bus.y = 10'd0;
    applyStimulus(1'b1, 240, 240);

    // Reset values, first step, bottom bounce, right miss, pause and re-serve.
    doReset();
    checkBall("reset", 320, 240);
    checkOutput("reset score1", bus.score1, 0);
    checkOutput("reset score2", bus.score2, 0);
    checkOutput("reset game_over", bus.game_over, 0);
    checkOutput("rgb_ball", bus.rgb_ball, 12'hFFF);
    bus.serve = 1'b0;
    clockCycle();
    bus.serve = 1'b1;
    clockCycle();
    checkBall("step1", 321, 241);
    runCycles(234);
    checkBall("step235", 555, 475);
    clockCycle();
    checkBall("step236", 556, 474);
    runCycles(79);
    checkBall("step315", 635, 395);
    checkOutput("miss score1", bus.score1, 1);
    checkOutput("miss score2", bus.score2, 0);
    runCycles(4);
    checkBall("point frozen", 635, 395);
    clockCycle();
    checkBall("recentre", 320, 240);
    checkOutput("recentre game_over", bus.game_over, 0);
    clockCycle();
    checkBall("idle parked", 320, 240);
    bus.serve = 1'b0;
    clockCycle();
    bus.serve = 1'b1;
    clockCycle();
    checkBall("reserve step1", 321, 239);

    // Right paddle return at step 276.
    doReset();
    applyStimulus(1'b0, 240, 434);
    clockCycle();
    bus.serve = 1'b1;
    runCycles(276);
    checkBall("hit step276", 596, 434);
    clockCycle();
    checkBall("hit step277", 595, 433);
    checkOutput("hit score1", bus.score1, 0);

    // Reset in the middle of a rally.
    doReset();
    applyStimulus(1'b0, 240, 240);
    clockCycle();
    bus.serve = 1'b1;
    runCycles(100);
    checkBall("step100", 420, 340);
    reset = 1'b0;
    clockCycle();
    reset = 1'b1;
    checkBall("mid reset", 320, 240);
    checkOutput("mid reset score1", bus.score1, 0);

    // Ball mask around the parked ball.
    foreach (pixVecs[i]) begin
      bus.x = pixVecs[i].px;
      bus.y = pixVecs[i].py;
      clockCycle();
      checkOutput($sformatf("ball_on[%0d]", i), bus.ball_on, pixVecs[i].expOn);
    end

    // Full game: right player never returns, so score1 climbs to the win.
    doReset();
    applyStimulus(1'b1, 240, 1000);
    for (int c = 0; c < 20000 && mState != M_OVER; c++) begin
      bus.serve = (mState == M_IDLE) ? 1'b0 : 1'b1;
      clockCycle();
      compareAll();
    end
    checkOutput("over score1", bus.score1, 7);
    checkOutput("over score2", bus.score2, 0);
    checkOutput("over game_over", bus.game_over, 1);
    checkBall("over", 320, 240);
    bus.serve = 1'b1;
    runCycles(3);
    checkOutput("over held", bus.game_over, 1);
    checkOutput("over held score1", bus.score1, 7);
    bus.serve = 1'b0;
    clockCycle();
    bus.serve = 1'b1;
    checkOutput("restart score1", bus.score1, 0);
    checkOutput("restart game_over", bus.game_over, 0);
    clockCycle();
    checkBall("restart idle", 320, 240);

    // Randomized play against the model.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      int yp1;
      int yp2;
      int px;
      int py;
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      bus.serve = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.x_paddle1 = 10'(PADDLE1_X - 3 + int'($urandom_range(0, 6)));
      bus.x_paddle2 = 10'(PADDLE2_X - 3 + int'($urandom_range(0, 6)));
      yp1 = ($urandom_range(0, 1) == 1) ? my - 30 + int'($urandom_range(0, 60))
                                        : int'($urandom_range(0, 479));
      yp2 = ($urandom_range(0, 1) == 1) ? my - 30 + int'($urandom_range(0, 60))
                                        : int'($urandom_range(0, 479));
      if (yp1 < 0) yp1 = 0;
      if (yp2 < 0) yp2 = 0;
      bus.y_paddle1 = 10'(yp1);
      bus.y_paddle2 = 10'(yp2);
      px = mx - 6 + int'($urandom_range(0, 12));
      py = my - 6 + int'($urandom_range(0, 12));
      bus.x = 10'(px);
      bus.y = 10'(py);
      clockCycle();
      compareAll();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
